// File: rtl/bus_write_ctrl_pkg.sv
// Shared definitions for the processor bus: write/read select codes,
// the decoded load-enable bundle and the data-memory write FSM states.
package bus_write_ctrl_pkg;

    // Select codes shared by the bus write decoder and the bus source mux.
    localparam logic [3:0] WE_NONE = 4'd0;
    localparam logic [3:0] WE_PC   = 4'd1;
    localparam logic [3:0] WE_DAR  = 4'd2;
    localparam logic [3:0] WE_IR   = 4'd4;
    localparam logic [3:0] WE_AC   = 4'd5;
    localparam logic [3:0] WE_R    = 4'd6;
    localparam logic [3:0] WE_R1   = 4'd7;
    localparam logic [3:0] WE_R2   = 4'd8;
    localparam logic [3:0] WE_R3   = 4'd9;
    localparam logic [3:0] WE_R4   = 4'd10;
    localparam logic [3:0] WE_R5   = 4'd11;
    localparam logic [3:0] WE_DM   = 4'd12;
    localparam logic [3:0] WE_IM   = 4'd13;

    // Width of the ack-timeout counter; covers timeouts up to 255 cycles.
    localparam int DM_CNT_W = 8;

    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_REQ  = 1'b1
    } dm_state_e;

    // One load enable per bus destination.
    typedef struct packed {
        logic pc;
        logic dar;
        logic ir;
        logic ac;
        logic r;
        logic r1;
        logic r2;
        logic r3;
        logic r4;
        logic r5;
        logic dm;
    } we_decode_t;

    // Decode a write-select code into at most one load enable.
    function automatic we_decode_t decode_write_sel(input logic [3:0] code);
        we_decode_t d;
        // NOTE: clear every field before the case so no bit keeps a stale
        // value and no latch is implied when this is used combinationally.
        d = '0;
        case (code)
            WE_PC:           d.pc  = 1'b1;
            WE_DAR:          d.dar = 1'b1;
            WE_IR:           d.ir  = 1'b1;
            WE_AC:           d.ac  = 1'b1;
            WE_R:            d.r   = 1'b1;
            WE_R1:           d.r1  = 1'b1;
            WE_R2:           d.r2  = 1'b1;
            WE_R3:           d.r3  = 1'b1;
            WE_R4:           d.r4  = 1'b1;
            WE_R5:           d.r5  = 1'b1;
            WE_DM:           d.dm  = 1'b1;
            // Instruction memory is read-only; the unused codes write nothing.
            WE_NONE, WE_IM:  ;
            default:         ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bus_write_ctrl_dm_write_fsm.sv
// Data-memory write handshake: latches address/data on start, holds the
// request until ack or until the ack timeout expires.
module dm_write_fsm
    import bus_write_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DM_WIDTH    = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_addr,
    input  logic [DM_WIDTH-1:0] i_data,
    input  logic                i_ack,
    output logic                o_req,
    output logic                o_busy,
    output logic [WIDTH-1:0]    o_addr,
    output logic [DM_WIDTH-1:0] o_data,
    output logic                o_timeout
);

    // Counter value of the last REQ cycle in which an ack is still accepted.
    localparam logic [DM_CNT_W-1:0] CNT_LAST = DM_CNT_W'(ACK_TIMEOUT - 1);

    dm_state_e              r_state;
    logic [DM_CNT_W-1:0]    r_cnt;
    logic                   r_req;
    logic [WIDTH-1:0]       r_addr;
    logic [DM_WIDTH-1:0]    r_data;
    logic                   r_timeout;

    // Handshake FSM with registered request, latches and sticky timeout.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // branch sees the pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state   <= DM_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                DM_IDLE: begin
                    if (i_start) begin
                        r_addr    <= i_addr;
                        r_data    <= i_data;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_req     <= 1'b1;
                        r_state   <= DM_REQ;
                    end
                end
                DM_REQ: begin
                    // A start request while busy is dropped, not queued.
                    if (i_ack) begin
                        r_req   <= 1'b0;
                        r_state <= DM_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= DM_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= DM_IDLE;
                end
            endcase
        end
    end

    assign o_req     = r_req;
    assign o_busy    = r_req;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_timeout = r_timeout;

endmodule

// File: rtl/bus_write_ctrl.sv
// Write side of the shared processor bus: register bank loaded from the bus,
// PC increment, AC clear, and the data-memory write handshake.
module bus_write_ctrl
    import bus_write_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DM_WIDTH    = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          write_en,
    input  logic [WIDTH-1:0]    busin,
    input  logic                pc_inc,
    input  logic                ac_clr,
    input  logic                dm_wr_ack,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    dar,
    output logic [WIDTH-1:0]    ir,
    output logic [WIDTH-1:0]    ac,
    output logic [WIDTH-1:0]    r,
    output logic [WIDTH-1:0]    r1,
    output logic [WIDTH-1:0]    r2,
    output logic [WIDTH-1:0]    r3,
    output logic [WIDTH-1:0]    r4,
    output logic [WIDTH-1:0]    r5,
    output logic                dm_wr_req,
    output logic [WIDTH-1:0]    dm_addr,
    output logic [DM_WIDTH-1:0] dm_wdata,
    output logic                dm_busy,
    output logic                dm_timeout
);

    we_decode_t       w_ld;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_dar;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_r3;
    logic [WIDTH-1:0] r_r4;
    logic [WIDTH-1:0] r_r5;

    assign w_ld = decode_write_sel(write_en);

    // Register bank: bus load beats pc_inc, ac_clr beats bus load.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_dar <= '0;
            r_ir  <= '0;
            r_ac  <= '0;
            r_r   <= '0;
            r_r1  <= '0;
            r_r2  <= '0;
            r_r3  <= '0;
            r_r4  <= '0;
            r_r5  <= '0;
        end else begin
            if (w_ld.pc)      r_pc <= busin;
            else if (pc_inc)  r_pc <= r_pc + WIDTH'(1);

            if (ac_clr)       r_ac <= '0;
            else if (w_ld.ac) r_ac <= busin;

            if (w_ld.dar)     r_dar <= busin;
            if (w_ld.ir)      r_ir  <= busin;
            if (w_ld.r)       r_r   <= busin;
            if (w_ld.r1)      r_r1  <= busin;
            if (w_ld.r2)      r_r2  <= busin;
            if (w_ld.r3)      r_r3  <= busin;
            if (w_ld.r4)      r_r4  <= busin;
            if (w_ld.r5)      r_r5  <= busin;
        end
    end

    assign pc = r_pc;
    assign dar = r_dar;
    assign ir = r_ir;
    assign ac = r_ac;
    assign r  = r_r;
    assign r1 = r_r1;
    assign r2 = r_r2;
    assign r3 = r_r3;
    assign r4 = r_r4;
    assign r5 = r_r5;

    // The write address is the DAR value before this edge's bus load.
    dm_write_fsm #(
        .WIDTH       (WIDTH),
        .DM_WIDTH    (DM_WIDTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dm_write_fsm (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_start   (w_ld.dm),
        .i_addr    (r_dar),
        .i_data    (busin[DM_WIDTH-1:0]),
        .i_ack     (dm_wr_ack),
        .o_req     (dm_wr_req),
        .o_busy    (dm_busy),
        .o_addr    (dm_addr),
        .o_data    (dm_wdata),
        .o_timeout (dm_timeout)
    );

endmodule

// File: tb/tb_bus_write_ctrl.sv
// Randomised and directed bench for bus_write_ctrl with a behavioural model.
module tb_bus_write_ctrl;

    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  write_en;
    logic [15:0] busin;
    logic        pc_inc, ac_clr, dm_wr_ack;
    logic [15:0] pc, dar, ir, ac, r, r1, r2, r3, r4, r5;
    logic        dm_wr_req, dm_busy, dm_timeout;
    logic [15:0] dm_addr;
    logic [7:0]  dm_wdata;

    int total = 0;
    int bad   = 0;

    bus_write_ctrl #(.WIDTH(16), .DM_WIDTH(8), .ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .write_en(write_en), .busin(busin),
        .pc_inc(pc_inc), .ac_clr(ac_clr), .dm_wr_ack(dm_wr_ack),
        .pc(pc), .dar(dar), .ir(ir), .ac(ac), .r(r),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
        .dm_wr_req(dm_wr_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_busy(dm_busy), .dm_timeout(dm_timeout)
    );

    always #5 clock = ~clock;

    // DUT register outputs in the order pc,dar,ir,ac,r,r1..r5.
    logic [15:0] dut_reg [10];
    assign dut_reg[0] = pc;
    assign dut_reg[1] = dar;
    assign dut_reg[2] = ir;
    assign dut_reg[3] = ac;
    assign dut_reg[4] = r;
    assign dut_reg[5] = r1;
    assign dut_reg[6] = r2;
    assign dut_reg[7] = r3;
    assign dut_reg[8] = r4;
    assign dut_reg[9] = r5;

    // Reference model state.
    logic [15:0] m_reg [10];
    logic        m_busy;
    int          m_left;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_timeout;

    function automatic int code_to_idx(input logic [3:0] code);
        case (code)
            4'd1: return 0;
            4'd2: return 1;
            4'd4: return 2;
            4'd5: return 3;
            4'd6: return 4;
            4'd7, 4'd8, 4'd9, 4'd10, 4'd11: return int'(code) - 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_update(input logic [3:0] we, input logic [15:0] bus,
                                input logic inc, input logic clr,
                                input logic ack, input logic rst_n);
        logic [15:0] old_dar;
        int idx;
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) m_reg[i] = '0;
            m_busy = 0; m_left = 0; m_addr = '0; m_data = '0; m_timeout = 0;
            return;
        end
        old_dar = m_reg[1];
        if (inc && we != 4'd1) m_reg[0] = m_reg[0] + 16'd1;
        idx = code_to_idx(we);
        if (idx >= 0) m_reg[idx] = bus;
        if (clr) m_reg[3] = '0;
        if (!m_busy) begin
            if (we == 4'd12) begin
                m_addr = old_dar; m_data = bus[7:0]; m_timeout = 0;
                m_busy = 1; m_left = TO;
            end
        end else if (ack) begin
            m_busy = 0;
        end else if (m_left == 1) begin
            m_busy = 0; m_timeout = 1;
        end else begin
            m_left = m_left - 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic step(input logic [3:0] we, input logic [15:0] bus,
                        input logic inc, input logic clr,
                        input logic ack, input logic rst_n);
        write_en = we; busin = bus; pc_inc = inc; ac_clr = clr;
        dm_wr_ack = ack; reset_n = rst_n;
        model_update(we, bus, inc, clr, ack, rst_n);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(4'd0, 16'h0000, 1'b0, 1'b0, ack, 1'b1);
    endtask

    task automatic test_reset;
        step(4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg[i] !== 16'h0000) begin
                bad++; $display("FAIL reset_reg%0d got=%h exp=0000", i, dut_reg[i]);
            end
        end
        total++;
        if ({dm_wr_req, dm_busy, dm_timeout, dm_addr, dm_wdata} !== 27'd0) begin
            bad++;
            $display("FAIL reset_dm got req=%b busy=%b to=%b addr=%h data=%h exp all 0",
                     dm_wr_req, dm_busy, dm_timeout, dm_addr, dm_wdata);
        end
    endtask

    task automatic test_reg_load;
        step(4'd7, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg[i] !== ((i == 5) ? 16'hA5A5 : 16'h0000)) begin
                bad++; $display("FAIL load_r1_reg%0d got=%h exp=%h", i, dut_reg[i],
                                (i == 5) ? 16'hA5A5 : 16'h0000);
            end
        end
    endtask

    task automatic test_pc_inc;
        step(4'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'd0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (pc !== 16'h0000) begin
            bad++; $display("FAIL pc_wrap got=%h exp=0000", pc);
        end
        step(4'd1, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (pc !== 16'h0040) begin
            bad++; $display("FAIL pc_load_beats_inc got=%h exp=0040", pc);
        end
        step(4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (pc !== 16'h0041) begin
            bad++; $display("FAIL pc_inc got=%h exp=0041", pc);
        end
    endtask

    task automatic test_ac_clr;
        step(4'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (ac !== 16'h1234) begin
            bad++; $display("FAIL ac_load got=%h exp=1234", ac);
        end
        step(4'd5, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (ac !== 16'h0000) begin
            bad++; $display("FAIL ac_clr_wins got=%h exp=0000", ac);
        end
    endtask

    task automatic test_dm_write;
        step(4'd2, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'd12, 16'h03C7, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({dm_wr_req, dm_busy, dm_addr, dm_wdata} !== {2'b11, 16'h0010, 8'hC7}) begin
            bad++; $display("FAIL dm_start got req=%b busy=%b addr=%h data=%h exp 1 1 0010 c7",
                            dm_wr_req, dm_busy, dm_addr, dm_wdata);
        end
        // Second start while busy, with a changed DAR, must be ignored.
        step(4'd2, 16'h0BEE, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'd12, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({dm_wr_req, dm_addr, dm_wdata} !== {1'b1, 16'h0010, 8'hC7}) begin
            bad++; $display("FAIL dm_busy_ignore got req=%b addr=%h data=%h exp 1 0010 c7",
                            dm_wr_req, dm_addr, dm_wdata);
        end
        step(4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if ({dm_wr_req, dm_busy, dm_timeout} !== 3'b000) begin
            bad++; $display("FAIL dm_ack_drop got req=%b busy=%b to=%b exp 0 0 0",
                            dm_wr_req, dm_busy, dm_timeout);
        end
        // Ack while idle does nothing.
        idle(1'b1);
        total++;
        if ({dm_wr_req, dm_addr, dm_wdata} !== {1'b0, 16'h0010, 8'hC7}) begin
            bad++; $display("FAIL dm_idle_ack got req=%b addr=%h data=%h exp 0 0010 c7",
                            dm_wr_req, dm_addr, dm_wdata);
        end
    endtask

    task automatic test_timeout;
        int high;
        step(4'd12, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b1);
        high = (dm_wr_req === 1'b1) ? 1 : 0;
        for (int g = 0; g < 40 && dm_wr_req === 1'b1; g++) begin
            total++;
            if (dm_timeout !== 1'b0) begin
                bad++; $display("FAIL to_early cycle=%0d got=%b exp=0", high, dm_timeout);
            end
            idle(1'b0);
            if (dm_wr_req === 1'b1) high++;
        end
        total++;
        if (high != TO || dm_wr_req !== 1'b0) begin
            bad++; $display("FAIL to_req_len got=%0d exp=%0d (req now %b)", high, TO, dm_wr_req);
        end
        total++;
        if (dm_timeout !== 1'b1) begin
            bad++; $display("FAIL to_flag got=%b exp=1", dm_timeout);
        end
        // A new write clears the sticky flag; ack in its first cycle.
        step(4'd12, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({dm_wr_req, dm_timeout} !== 2'b10) begin
            bad++; $display("FAIL to_clear got req=%b to=%b exp 1 0", dm_wr_req, dm_timeout);
        end
        idle(1'b1);
        total++;
        if ({dm_wr_req, dm_timeout} !== 2'b00) begin
            bad++; $display("FAIL to_min_txn got req=%b to=%b exp 0 0", dm_wr_req, dm_timeout);
        end
    endtask

    task automatic test_ack_last_cycle;
        step(4'd12, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < TO - 1; i++) idle(1'b0);
        total++;
        if (dm_wr_req !== 1'b1) begin
            bad++; $display("FAIL last_pre got req=%b exp=1", dm_wr_req);
        end
        idle(1'b1);
        total++;
        if ({dm_wr_req, dm_timeout} !== 2'b00) begin
            bad++; $display("FAIL last_ack got req=%b to=%b exp 0 0", dm_wr_req, dm_timeout);
        end
    endtask

    task automatic test_no_write_codes;
        logic [3:0] codes [5];
        logic [15:0] snap [10];
        codes[0] = 4'd13; codes[1] = 4'd3; codes[2] = 4'd0;
        codes[3] = 4'd14; codes[4] = 4'd15;
        for (int i = 0; i < 10; i++) snap[i] = m_reg[i];
        for (int c = 0; c < 5; c++) begin
            step(codes[c], 16'($urandom()), 1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 10; i++) begin
                total++;
                if (dut_reg[i] !== snap[i]) begin
                    bad++; $display("FAIL nowrite_code%0d_reg%0d got=%h exp=%h",
                                    codes[c], i, dut_reg[i], snap[i]);
                end
            end
            total++;
            if (dm_wr_req !== 1'b0) begin
                bad++; $display("FAIL nowrite_code%0d_req got=%b exp=0", codes[c], dm_wr_req);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(4'd11, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'd12, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(4'd1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dut_reg[i] !== 16'h0000) begin
                bad++; $display("FAIL midrst_reg%0d got=%h exp=0000", i, dut_reg[i]);
            end
        end
        total++;
        if ({dm_wr_req, dm_busy, dm_timeout} !== 3'b000) begin
            bad++; $display("FAIL midrst_dm got req=%b busy=%b to=%b exp 0 0 0",
                            dm_wr_req, dm_busy, dm_timeout);
        end
    endtask

    task automatic test_random;
        logic [3:0] we;
        logic ack;
        for (int c = 0; c < 600; c++) begin
            we  = ($urandom_range(0, 5) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
            ack = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step(we, 16'($urandom()), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), ack, 1'($urandom_range(0, 79) != 0));
            for (int i = 0; i < 10; i++) begin
                total++;
                if (dut_reg[i] !== m_reg[i]) begin
                    bad++; $display("FAIL rand_reg%0d cyc=%0d got=%h exp=%h",
                                    i, c, dut_reg[i], m_reg[i]);
                end
            end
            total++;
            if ({dm_wr_req, dm_busy, dm_timeout, dm_addr, dm_wdata} !==
                {m_busy, m_busy, m_timeout, m_addr, m_data}) begin
                bad++;
                $display("FAIL rand_dm cyc=%0d got req=%b busy=%b to=%b addr=%h data=%h exp %b %b %b %h %h",
                         c, dm_wr_req, dm_busy, dm_timeout, dm_addr, dm_wdata,
                         m_busy, m_busy, m_timeout, m_addr, m_data);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; write_en = '0; busin = '0;
        pc_inc = 1'b0; ac_clr = 1'b0; dm_wr_ack = 1'b0;
        #1;
        test_reset;
        test_reg_load;
        test_pc_inc;
        test_ac_clr;
        test_dm_write;
        test_timeout;
        test_ack_last_cycle;
        test_no_write_codes;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_write_ctrl.md
# bus_write_ctrl

Write-side counterpart of the processor's shared 16-bit bus. It decodes a 4-bit write-select code and loads the bus value into the selected architectural register (PC, DAR, IR, AC, R, R1–R5). It also starts a handshaked byte write to data memory. It holds every bus-source register, so its register outputs feed the bus source multiplexer directly. It also supports PC increment and AC clear for the control unit.

## Interface
Parameters:
- WIDTH, 16, bus and register width
- DM_WIDTH, 8, data-memory word width; the low DM_WIDTH bits of the bus are written
- ACK_TIMEOUT, 15, maximum cycles spent waiting for dm_wr_ack (1..255)

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- write_en  in  4  destination select, same encoding as the bus read select: 1 pc, 2 dar, 4 ir, 5 ac, 6 r, 7–11 r1–r5, 12 dm; 0/3/13/14/15 no write
- busin  in  WIDTH  current bus value
- pc_inc  in  1  increment PC by 1
- ac_clr  in  1  clear AC to 0
- dm_wr_ack  in  1  data memory accepted the write
- pc, dar, ir, ac, r, r1, r2, r3, r4, r5  out  WIDTH each  register contents
- dm_wr_req  out  1  write request to data memory
- dm_addr  out  WIDTH  latched write address
- dm_wdata  out  DM_WIDTH  latched write data
- dm_busy  out  1  memory write in progress
- dm_timeout  out  1  sticky flag: last memory write got no ack within the timeout

## Operation
- Register load: when write_en selects a register, that register takes busin at the edge. Every other register holds.
- Code 13 is instruction memory, which is read-only. Codes 13, 3, 0, 14 and 15 change nothing.
- pc_inc: pc <= pc + 1, modulo 2^WIDTH, so 16'hFFFF wraps to 0.
  - If write_en=1 in the same cycle, the bus load wins and the increment is dropped.
- ac_clr: ac <= 0.
  - If write_en=5 in the same cycle, the clear wins.
- Data-memory write FSM, states IDLE, REQ:
  - IDLE, write_en=12: latch dm_addr <= dar (the pre-edge value) and dm_wdata <= busin[DM_WIDTH-1:0]. Clear the timeout counter and dm_timeout. Go to REQ.
  - IDLE, any other write_en: stay in IDLE.
  - REQ, dm_wr_ack=1: go to IDLE.
  - REQ, dm_wr_ack=0 and counter = ACK_TIMEOUT-1: set dm_timeout=1 and go to IDLE.
  - REQ, otherwise: increment the counter and stay in REQ.
  - REQ, write_en=12 seen while busy: ignored, no queueing. dm_addr and dm_wdata stay stable.
  - The other register codes are still honoured while the FSM is in REQ.
- dm_wr_req = dm_busy = (state == REQ).
- Reset has priority over all inputs and may occur mid-transaction. The FSM returns to IDLE and the request drops on the next cycle.

## Timing
- Every output is registered.
- Reset values:
  - all registers 0
  - dm_addr 0, dm_wdata 0
  - dm_wr_req 0, dm_busy 0, dm_timeout 0
  - FSM in IDLE, counter 0
- Register write latency: a value presented with write_en in cycle N is visible on the output in cycle N+1.
- Memory write:
  - dm_wr_req rises in cycle N+1 after write_en=12 in cycle N.
  - If ack is high in cycle M, dm_wr_req is low from M+1.
  - Minimum transaction length is 1 request cycle, when ack comes in the first REQ cycle.
- Timeout: with no ack, dm_wr_req is high for exactly ACK_TIMEOUT cycles, and dm_timeout rises on the cycle it drops.
- If dm_wr_ack arrives in the last allowed cycle, the ack takes priority and no timeout is flagged.
- dm_wr_ack while in IDLE is ignored.

## Structure
- Shared package holds:
  - write-select code constants: WE_NONE, WE_PC, WE_DAR, WE_IR, WE_AC, WE_R, WE_R1..WE_R5, WE_DM, WE_IM
  - the FSM state typedef
- The bus source mux imports the same code constants, so read and write encodings cannot diverge.
- One sub-module, dm_write_fsm, contains the handshake FSM, the timeout counter and the address/data latches. The top level keeps the register bank and the decode logic.

## Test plan
- Reset, then write_en=7 with busin=16'hA5A5 → r1=16'hA5A5 next cycle; all other registers stay 0.
- pc=16'hFFFF with pc_inc → pc=0.
  - Then pc_inc with write_en=1 and busin=16'h0040 → pc=16'h0040.
- ac=16'h1234 with ac_clr and write_en=5 (busin=16'h00FF) in the same cycle → ac=0.
- dar=16'h0010, write_en=12, busin=16'h03C7 → dm_addr=16'h0010, dm_wdata=8'hC7, dm_wr_req high next cycle.
  - ack after 3 cycles → req low the following cycle.
  - A second write_en=12 issued while busy → no change to dm_addr/dm_wdata.
- write_en=12 and ack never arrives → dm_wr_req high for exactly 15 cycles, then dm_timeout=1.
  - A next successful dm write clears dm_timeout.
- reset_n low during REQ → the next cycle shows dm_wr_req=0, every register 0 and dm_timeout=0.
  - write_en=13 or 3 → no register changes.
